// File: rtl/ddr_stream_writer.sv
// Streams 512-bit AXI-Stream beats into DDR as aligned AXI4 INCR bursts, one burst in flight at a time.
// Optional macro DDR_WR_ERR_COUNT_EN adds a saturating err_cnt output counting non-OKAY write responses.
module ddr_stream_writer #(
    parameter int BURST_LEN = 64
) (
    input  logic         ddr_clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  base_addr,
    input  logic [31:0]  num_beats,
    output logic         busy,
    output logic         done,
    output logic [31:0]  beats_written,
    output logic         bresp_err,
    input  logic [511:0] from_app_tdata,
    input  logic [63:0]  from_app_tkeep,
    input  logic         from_app_tlast,
    input  logic         from_app_tvalid,
    output logic         from_app_tready,
    output logic [63:0]  to_ddr_awaddr,
    output logic [7:0]   to_ddr_awlen,
    output logic [2:0]   to_ddr_awsize,
    output logic [1:0]   to_ddr_awburst,
    output logic [3:0]   to_ddr_awcache,
    output logic [2:0]   to_ddr_awprot,
    output logic [3:0]   to_ddr_awuser,
    output logic         to_ddr_awvalid,
    input  logic         to_ddr_awready,
    output logic [511:0] to_ddr_wdata,
    output logic [63:0]  to_ddr_wstrb,
    output logic         to_ddr_wlast,
    output logic         to_ddr_wvalid,
    input  logic         to_ddr_wready,
    input  logic [1:0]   to_ddr_bresp,
    input  logic         to_ddr_bvalid,
    output logic         to_ddr_bready
`ifdef DDR_WR_ERR_COUNT_EN
    ,
    output logic [15:0]  err_cnt
`endif
);

    // Base address is aligned to a whole burst, which also keeps every burst inside one 4 KB page.
    localparam int          ALIGN_BITS  = $clog2(BURST_LEN * 64);
    localparam logic [63:0] ALIGN_MASK  = ~((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [8:0]  BURST_BEATS = 9'(BURST_LEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] addr_q, addr_d;
    logic [31:0] remain_q, remain_d;
    logic [7:0]  beat_q, beat_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] wcount_q, wcount_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [8:0]  burst_beats_s;
    logic [7:0]  awlen_s;
    logic        w_hs_s;
    logic        wlast_s;

    assign burst_beats_s = (remain_q >= 32'(BURST_LEN)) ? BURST_BEATS : remain_q[8:0];
    assign awlen_s       = 8'(burst_beats_s - 9'd1);
    assign w_hs_s        = (state_q == S_DATA) && from_app_tvalid && to_ddr_wready;
    assign wlast_s       = (state_q == S_DATA) && (beat_q == awlen_s);

    // Next-state and datapath update logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        beat_d    = beat_q;
        done_d    = done_q;
        err_d     = err_q;
        wcount_d  = wcount_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d    = (num_beats == 32'd0);
                    err_d     = 1'b0;
                    wcount_d  = 32'd0;
                    err_cnt_d = 16'd0;
                    addr_d    = base_addr & ALIGN_MASK;
                    remain_d  = num_beats;
                    beat_d    = 8'd0;
                    state_d   = (num_beats == 32'd0) ? S_IDLE : S_ADDR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ADDR: begin
                if (to_ddr_awready) begin
                    beat_d  = 8'd0;
                    state_d = S_DATA;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_hs_s) begin
                    wcount_d = wcount_q + 32'd1;
                    beat_d   = beat_q + 8'd1;
                    state_d  = wlast_s ? S_RESP : S_DATA;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_RESP: begin
                if (to_ddr_bvalid) begin
                    if (to_ddr_bresp != 2'b00) begin
                        err_d     = 1'b1;
                        err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                    end else begin
                        err_d = err_q;
                    end
                    remain_d = remain_q - 32'(burst_beats_s);
                    addr_d   = addr_q + (64'(burst_beats_s) << 6);
                    if (remain_d == 32'd0) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_ADDR;
                    end
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge ddr_clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= 64'd0;
            remain_q  <= 32'd0;
            beat_q    <= 8'd0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            wcount_q  <= 32'd0;
            err_cnt_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
            err_q     <= err_d;
            wcount_q  <= wcount_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign beats_written = wcount_q;
    assign bresp_err     = err_q;

    assign to_ddr_awaddr  = addr_q;
    assign to_ddr_awlen   = awlen_s;
    assign to_ddr_awsize  = 3'b110;
    assign to_ddr_awburst = 2'b01;
    assign to_ddr_awcache = 4'b0011;
    assign to_ddr_awprot  = 3'b000;
    assign to_ddr_awuser  = 4'b0000;
    assign to_ddr_awvalid = (state_q == S_ADDR);

    // Data path is a zero-latency pass-through gated by the DATA state; tlast is not used.
    assign to_ddr_wdata    = from_app_tdata;
    assign to_ddr_wstrb    = from_app_tkeep;
    assign to_ddr_wvalid   = (state_q == S_DATA) && from_app_tvalid;
    assign to_ddr_wlast    = wlast_s;
    assign from_app_tready = (state_q == S_DATA) && to_ddr_wready;
    assign to_ddr_bready   = (state_q == S_RESP);

`ifdef DDR_WR_ERR_COUNT_EN
    assign err_cnt = err_cnt_q;
`endif

    logic unused_s;
    assign unused_s = from_app_tlast;

endmodule

// File: tb/tb_ddr_stream_writer.sv
// Randomized self-checking bench for ddr_stream_writer; a queue-based burst/beat model predicts DDR traffic.
module tb_ddr_stream_writer;

    localparam int BL = 64;

    logic         ddr_clk = 1'b0;
    logic         rst, start;
    logic [63:0]  base_addr;
    logic [31:0]  num_beats;
    logic         busy, done, bresp_err;
    logic [31:0]  beats_written;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tlast, tvalid, tready;
    logic [63:0]  awaddr;
    logic [7:0]   awlen;
    logic [2:0]   awsize;
    logic [1:0]   awburst;
    logic [3:0]   awcache;
    logic [2:0]   awprot;
    logic [3:0]   awuser;
    logic         awvalid, awready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast, wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
`ifdef DDR_WR_ERR_COUNT_EN
    logic [15:0]  err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ddr_clk = ~ddr_clk;

    ddr_stream_writer #(.BURST_LEN(BL)) dut (
        .ddr_clk(ddr_clk), .rst(rst), .start(start), .base_addr(base_addr), .num_beats(num_beats),
        .busy(busy), .done(done), .beats_written(beats_written), .bresp_err(bresp_err),
        .from_app_tdata(tdata), .from_app_tkeep(tkeep), .from_app_tlast(tlast),
        .from_app_tvalid(tvalid), .from_app_tready(tready),
        .to_ddr_awaddr(awaddr), .to_ddr_awlen(awlen), .to_ddr_awsize(awsize), .to_ddr_awburst(awburst),
        .to_ddr_awcache(awcache), .to_ddr_awprot(awprot), .to_ddr_awuser(awuser),
        .to_ddr_awvalid(awvalid), .to_ddr_awready(awready),
        .to_ddr_wdata(wdata), .to_ddr_wstrb(wstrb), .to_ddr_wlast(wlast), .to_ddr_wvalid(wvalid),
        .to_ddr_wready(wready), .to_ddr_bresp(bresp), .to_ddr_bvalid(bvalid), .to_ddr_bready(bready)
`ifdef DDR_WR_ERR_COUNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    task automatic check_val(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; tvalid = 1'b0; tlast = 1'b0; awready = 1'b0; wready = 1'b0;
        bvalid = 1'b0; bresp = 2'b00; tdata = '0; tkeep = '0;
    endtask

    // One capture: model predicts the AW list and beat order; a random slave and source exercise it.
    task automatic run_xfer(input logic [63:0] base, input int n, input bit full,
                            input int err_burst, input bit busy_start, input int abort_at);
        logic [511:0] dq[$];
        logic [63:0]  kq[$];
        logic [63:0]  exp_addr[$];
        int           exp_len[$];
        logic [63:0]  a;
        int rem, b, src, aw_i, w_i, wb, bur, b_i, cyc, nb;
        bit hold, bpend, bhold, exp_err;

        dq.delete(); kq.delete(); exp_addr.delete(); exp_len.delete();
        a = base & ~(64'(BL * 64) - 64'd1);
        rem = n;
        while (rem > 0) begin
            b = (rem < BL) ? rem : BL;
            exp_addr.push_back(a);
            exp_len.push_back(b - 1);
            a   = a + 64'(b) * 64'd64;
            rem = rem - b;
        end
        nb = exp_addr.size();
        for (int i = 0; i < n; i++) begin
            logic [511:0] d;
            for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
            dq.push_back(d);
            kq.push_back({$urandom, $urandom});
        end
        exp_err = (err_burst >= 0) && (err_burst < nb);

        @(negedge ddr_clk);
        start = 1'b1; base_addr = base; num_beats = 32'(n);
        @(negedge ddr_clk);
        start = 1'b0; base_addr = {$urandom, $urandom}; num_beats = $urandom;

        src = 0; aw_i = 0; w_i = 0; wb = 0; bur = 0; b_i = 0; cyc = 0;
        hold = 1'b0; bpend = 1'b0; bhold = 1'b0;
        while (cyc < 20000) begin
            if (abort_at >= 0 && w_i == abort_at) begin
                rst = 1'b1; wready = 1'b1; awready = 1'b1; tvalid = 1'b1; bvalid = 1'b0;
                @(negedge ddr_clk);
                #1;
                check_val("abort_busy", busy, 1'b0);
                check_val("abort_done", done, 1'b0);
                check_val("abort_bw", beats_written, 32'd0);
                check_val("abort_awvalid", awvalid, 1'b0);
                check_val("abort_wvalid", wvalid, 1'b0);
                check_val("abort_tready", tready, 1'b0);
                check_val("abort_bready", bready, 1'b0);
                rst = 1'b0;
                idle_inputs();
                return;
            end
            awready = full ? 1'b1 : 1'($urandom_range(0, 1));
            wready  = full ? 1'b1 : 1'($urandom_range(0, 1));
            if (hold) tvalid = 1'b1;
            else tvalid = (src < n) && (full || ($urandom_range(0, 1) == 1));
            tdata = (src < n) ? dq[src] : '0;
            tkeep = (src < n) ? kq[src] : '0;
            if (!bhold) bvalid = bpend && (full || ($urandom_range(0, 1) == 1));
            bresp = (b_i == err_burst) ? 2'b10 : 2'b00;
            start = busy_start && (cyc == 3);
            #1;
            if (cyc == 0) begin
                check_val("done_cleared", done, 1'b0);
                check_val("busy_on", busy, 1'b1);
            end
            if (awvalid && awready) begin
                if (aw_i < nb) begin
                    check_val("awaddr", awaddr, exp_addr[aw_i]);
                    check_val("awlen", awlen, 8'(exp_len[aw_i]));
                    check_val("aw_const", {awsize, awburst, awcache, awprot, awuser},
                              {3'b110, 2'b01, 4'b0011, 3'b000, 4'b0000});
                end else check_val("aw_extra", 1'b1, 1'b0);
                aw_i++;
            end
            if (!wready) check_val("tready_no_wready", tready, 1'b0);
            check_val("stream_eq_ddr", tvalid && tready, wvalid && wready);
            if (wvalid && wready) begin
                if (w_i < n && bur < nb) begin
                    check_val("wdata", wdata, dq[w_i]);
                    check_val("wstrb", wstrb, kq[w_i]);
                    check_val("wlast", wlast, wb == exp_len[bur]);
                    if (wb == exp_len[bur]) begin
                        bpend = 1'b1; bur++; wb = 0;
                    end else wb++;
                end else check_val("w_extra", 1'b1, 1'b0);
                w_i++;
            end
            if (tvalid && tready) begin src++; hold = 1'b0; end
            else hold = tvalid;
            if (bvalid && bready) begin bpend = 1'b0; bhold = 1'b0; b_i++; end
            else bhold = bvalid;
            if (done) break;
            cyc++;
            @(negedge ddr_clk);
        end
        check_val("done_in_time", done, 1'b1);
        check_val("busy_end", busy, 1'b0);
        check_val("beats_written", beats_written, 32'(n));
        check_val("bresp_err", bresp_err, exp_err);
        check_val("aw_count", 32'(aw_i), 32'(nb));
        check_val("w_count", 32'(w_i), 32'(n));
        check_val("b_count", 32'(b_i), 32'(nb));
`ifdef DDR_WR_ERR_COUNT_EN
        check_val("err_cnt", err_cnt, exp_err ? 16'd1 : 16'd0);
`endif
        idle_inputs();
    endtask

    initial begin
        bit seen_aw;
        idle_inputs();
        base_addr = 64'd0; num_beats = 32'd0;
        rst = 1'b1;
        repeat (3) @(negedge ddr_clk);
        #1;
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_done", done, 1'b0);
        check_val("rst_err", bresp_err, 1'b0);
        check_val("rst_bw", beats_written, 32'd0);
        check_val("rst_awvalid", awvalid, 1'b0);
        check_val("rst_bready", bready, 1'b0);
        check_val("rst_tready", tready, 1'b0);
        rst = 1'b0;

        run_xfer(64'h1000, 64, 1'b1, -1, 1'b0, -1);
        run_xfer(64'h0, 150, 1'b1, -1, 1'b0, -1);
        run_xfer(64'h0000_0000_0012_3456, 150, 1'b0, 1, 1'b0, -1);
        run_xfer({$urandom, $urandom}, 100, 1'b0, -1, 1'b1, -1);

        @(negedge ddr_clk);
        start = 1'b1; num_beats = 32'd0; base_addr = 64'h5000;
        @(negedge ddr_clk);
        start = 1'b0;
        #1;
        check_val("zero_done", done, 1'b1);
        check_val("zero_busy", busy, 1'b0);
        check_val("zero_bw", beats_written, 32'd0);
        seen_aw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge ddr_clk);
            #1;
            if (awvalid) seen_aw = 1'b1;
        end
        check_val("zero_no_aw", seen_aw, 1'b0);

        run_xfer(64'h2000, 64, 1'b1, -1, 1'b0, 10);
        run_xfer(64'h3000, 40, 1'b1, -1, 1'b0, -1);
        run_xfer(64'hFFFF_FFFF_FFFF_F000, 150, 1'b0, 2, 1'b0, -1);
        for (int r = 0; r < 6; r++) begin
            run_xfer({$urandom, $urandom}, int'($urandom_range(1, 200)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 3)) - 1, 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddr_stream_writer.md
DDR_STREAM_WRITER -- requirements
Module: ddr_stream_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 64, meaning beats per full AXI write burst (power of 2, 1..64).
REQ-002 SHALL have ports: ddr_clk in 1 sole clock; rst in 1 reset, synchronous, active-high.
REQ-003 SHALL have ports: start in 1 capture-start pulse; base_addr in 64 DDR byte address; num_beats in 32 total 512-bit beats to capture.
REQ-004 SHALL have ports: busy out 1; done out 1 sticky completion; beats_written out 32; bresp_err out 1 sticky non-OKAY response.
REQ-005 SHALL have slave stream ports: from_app_tdata in 512; from_app_tkeep in 64; from_app_tlast in 1 (ignored); from_app_tvalid in 1; from_app_tready out 1.
REQ-006 SHALL have write-address ports: to_ddr_awaddr out 64; to_ddr_awlen out 8; to_ddr_awsize out 3; to_ddr_awburst out 2; to_ddr_awcache out 4; to_ddr_awprot out 3; to_ddr_awuser out 4; to_ddr_awvalid out 1; to_ddr_awready in 1.
REQ-007 SHALL have write-data/response ports: to_ddr_wdata out 512; to_ddr_wstrb out 64; to_ddr_wlast out 1; to_ddr_wvalid out 1; to_ddr_wready in 1; to_ddr_bresp in 2; to_ddr_bvalid in 1; to_ddr_bready out 1.

Function
REQ-008 SHALL implement FSM IDLE, ADDR, DATA, RESP with one burst outstanding at a time.
REQ-009 IDLE: start=1 SHALL latch base_addr (low log2(BURST_LEN*64) bits forced 0) and num_beats, clear done, bresp_err, beats_written, enter ADDR next cycle.
REQ-010 start with num_beats=0 SHALL set done the next cycle and stay in IDLE, no AXI traffic.
REQ-011 start while busy SHALL be ignored.
REQ-012 ADDR: awvalid=1, awlen=min(remaining,BURST_LEN)-1, awaddr=current address; held stable until awready; on handshake enter DATA.
REQ-013 Constants: awsize=3'b110, awburst=2'b01, awcache=4'b0011, awprot=0, awuser=0.
REQ-014 DATA: wvalid=from_app_tvalid, from_app_tready=wready, wdata=tdata, wstrb=tkeep, combinational pass-through, zero latency.
REQ-015 wlast SHALL assert on the awlen+1-th beat of the burst; after that handshake enter RESP.
REQ-016 from_app_tready SHALL be 0 in every state except DATA.
REQ-017 RESP: bready=1; on bvalid, bresp!=2'b00 sets bresp_err; remaining -= burst beats; address += burst beats*64 (64-bit wrap).
REQ-018 After RESP: remaining>0 -> ADDR; remaining=0 -> IDLE with done=1 same edge.
REQ-019 beats_written SHALL increment on every W handshake, 32-bit wrapping.
REQ-020 busy SHALL be 1 in ADDR, DATA, RESP, else 0.
REQ-021 Bursts SHALL never cross a 4 KB boundary (guaranteed by REQ-009 alignment).
REQ-022 awvalid, wvalid SHALL never deassert before their handshake once asserted (wvalid follows tvalid per AXIS rule that tvalid holds).

Reset
REQ-023 rst=1 at a ddr_clk edge SHALL force IDLE, busy=0, done=0, bresp_err=0, beats_written=0, awvalid=0, bready=0, from_app_tready=0.
REQ-024 rst mid-burst SHALL abort immediately with no further AXI signalling; downstream recovery is the system's duty.

Configuration
REQ-025 Macro DDR_WR_ERR_COUNT_EN defined: SHALL add output err_cnt 16 counting non-OKAY B responses, saturating at 16'hFFFF, cleared by start and rst.
REQ-026 Macro undefined: err_cnt port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-027 num_beats=64, base 0x1000, always-ready slave -> one AW awaddr=0x1000 awlen=63, 64 W beats, wlast on 64th, done=1, beats_written=64.
REQ-028 num_beats=150, base 0x0 -> AWs at 0x0/0x1000/0x2000 with awlen 63/63/21, done after third B.
REQ-029 wready toggled 50%, tvalid gaps -> data sequence at DDR equals stream exactly, no dropped or duplicated beats.
REQ-030 bresp=2'b10 on second of three bursts -> bresp_err=1 sticky, transfer completes; err_cnt=1 when DDR_WR_ERR_COUNT_EN.
REQ-031 rst asserted in DATA at beat 10 -> next cycle IDLE, all outputs at reset values; new start runs normally.
REQ-032 start with num_beats=0 -> done=1 one cycle later, awvalid never asserts; start while busy -> no effect.
